fir_tap_sequencer: RTL



---
 rtl/fir_tap_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer
//   Time-multiplexed FIR controller. Each rising edge of the sample strobe
//   writes the new sample into an external dual-port ring buffer, then walks
//   all taps newest-to-oldest through one shared signed multiplier and
//   accumulator, and emits one filtered sample with a 1-cycle valid pulse.
//
//   Ports:
//     clk_i, rst_ni        clock, synchronous active-low reset
//     valid_strobe_i       sample strobe (rising edge only)
//     data_in_i            sample, captured on the detected edge
//     mem_wvalid_o/waddr_o/wdata_o   ring buffer write port
//     mem_raddr_o, mem_rdata_i       ring buffer read port (1-cycle latency)
//     coef_addr_o, coef_i            coefficient ROM (1-cycle latency)
//     y_o, y_valid_o       filtered sample (held) and its update pulse
//     busy_o               high whenever the sequencer is not idle
//     overrun_o            sticky: strobe edge seen while not idle
//
//   Build option: define FIR_SEQ_SATURATE_EN to clamp the output to the
//   signed DATA_WIDTH range instead of wrapping.
module fir_tap_sequencer #(
  parameter int unsigned NUM_TAPS   = 5,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned OUT_SHIFT  = 15,
  localparam int unsigned CAW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_strobe_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic                  mem_wvalid_o,
  output logic [ADDR_WIDTH-1:0] mem_waddr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [CAW-1:0]        coef_addr_o,
  input  logic [COEF_WIDTH-1:0] coef_i,
  output logic [DATA_WIDTH-1:0] y_o,
  output logic                  y_valid_o,
  output logic                  busy_o,
  output logic                  overrun_o
);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_WRITE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] CLR_END = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CAW-1:0]      LAST_K  = CAW'(NUM_TAPS - 1);

  state_t state_q, state_d;
  logic   strobe_q;
  logic   edge_det;

  logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CAW-1:0]        k_q, k_d, k_inc;

  logic signed [DATA_WIDTH+COEF_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]             acc_q, acc_d, acc_sum;
  logic        [DATA_WIDTH-1:0]            y_next;

  logic                  wvalid_d, y_valid_d, busy_d, overrun_d;
  logic [ADDR_WIDTH-1:0] waddr_d, raddr_d;
  logic [DATA_WIDTH-1:0] wdata_d, y_d;
  logic [CAW-1:0]        coef_addr_d;

  assign edge_det = valid_strobe_i & ~strobe_q;
  assign product  = $signed(mem_rdata_i) * $signed(coef_i);
  assign acc_sum  = acc_q + ACC_WIDTH'(product);
  assign k_inc    = k_q + CAW'(1);

`ifdef FIR_SEQ_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH-1:0] acc_shift;
  assign acc_shift = acc_sum >>> OUT_SHIFT;

  always_comb begin
    if (acc_shift > SAT_MAX)      y_next = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (acc_shift < SAT_MIN) y_next = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                          y_next = acc_shift[DATA_WIDTH-1:0];
  end
`else
  assign y_next = DATA_WIDTH'(acc_sum >>> OUT_SHIFT);
`endif

  // All outputs are registered: each *_d value is what the output must show
  // during the cycle spent in state_d, so outputs line up with the state.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    base_d      = base_q;
    k_d         = k_q;
    acc_d       = acc_q;
    wvalid_d    = 1'b0;
    waddr_d     = mem_waddr_o;
    wdata_d     = mem_wdata_o;
    raddr_d     = mem_raddr_o;
    coef_addr_d = coef_addr_o;
    y_d         = y_o;
    y_valid_d   = 1'b0;
    overrun_d   = overrun_o;

    if (edge_det && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_CLEAR: begin
        if (clr_cnt_q == CLR_END) begin
          state_d = S_IDLE;
        end else begin
          wvalid_d  = 1'b1;
          waddr_d   = clr_cnt_q[ADDR_WIDTH-1:0];
          wdata_d   = '0;
          clr_cnt_d = clr_cnt_q + (ADDR_WIDTH+1)'(1);
        end
      end
      S_IDLE: begin
        if (edge_det) begin
          state_d  = S_WRITE;
          wvalid_d = 1'b1;
          waddr_d  = wr_ptr_q;
          wdata_d  = data_in_i;
        end
      end
      S_WRITE: begin
        base_d      = wr_ptr_q;
        wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(1);
        acc_d       = '0;
        k_d         = '0;
        raddr_d     = wr_ptr_q;
        coef_addr_d = '0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        // Read data trails the address by one cycle, so tap k-1 is summed here.
        if (k_q != '0) acc_d = acc_sum;
        if (k_q == LAST_K) begin
          state_d = S_DRAIN;
        end else begin
          k_d         = k_inc;
          raddr_d     = base_q - ADDR_WIDTH'(k_inc);
          coef_addr_d = k_inc;
        end
      end
      S_DRAIN: begin
        // Last product and output scaling happen on the same edge.
        acc_d     = acc_sum;
        y_d       = y_next;
        y_valid_d = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_CLEAR;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_CLEAR;
      strobe_q     <= 1'b0;
      clr_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      base_q       <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      mem_wvalid_o <= 1'b0;
      mem_waddr_o  <= '0;
      mem_wdata_o  <= '0;
      mem_raddr_o  <= '0;
      coef_addr_o  <= '0;
      y_o          <= '0;
      y_valid_o    <= 1'b0;
      busy_o       <= 1'b1;
      overrun_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      strobe_q     <= valid_strobe_i;
      clr_cnt_q    <= clr_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      base_q       <= base_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      mem_wvalid_o <= wvalid_d;
      mem_waddr_o  <= waddr_d;
      mem_wdata_o  <= wdata_d;
      mem_raddr_o  <= raddr_d;
      coef_addr_o  <= coef_addr_d;
      y_o          <= y_d;
      y_valid_o    <= y_valid_d;
      busy_o       <= busy_d;
      overrun_o    <= overrun_d;
    end
  end

endmodule
